// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversampled mode-0 slave that decodes host command
// frames, walks the CMD0/CMD8/ACMD41 init flow and serves CMD17 sector reads.
module sd_spi_responder #(
  parameter int          RESP_DELAY   = 1,
  parameter int          ACCESS_DELAY = 2,
  parameter int          INIT_POLLS   = 3,
  parameter logic [25:0] MAX_SECTOR   = 26'h3FFFFFF,
  parameter bit          CHECK_CRC    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        spi_clk,
  input  logic        mosi,
  output logic        miso,
  output logic [25:0] rd_sector,
  output logic        rd_start,
  output logic        rd_strobe,
  input  logic [7:0]  rd_data,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);
  // state     | meaning
  // HUNT      | waiting for a byte starting with 2'b01
  // CMD_BYTES | collecting 4 argument bytes and the CRC byte
  // NCR       | sending 0xFF filler before the response
  // RESP      | sending R1/R3/R7 bytes
  // ACCESS    | sending 0xFF between the read R1 and the start token
  // TOKEN     | sending the 0xFE start token
  // DATA      | sending the 512 sector bytes
  // CRC       | sending the two dummy data-CRC bytes
  typedef enum logic [2:0] {HUNT, CMD_BYTES, NCR, RESP, ACCESS, TOKEN, DATA, CRC} state_t;

  localparam logic [7:0] POLLS = 8'(INIT_POLLS);

  state_t      state, state_nx;
  logic [1:0]  cs_sync, sclk_sync, mosi_sync;
  logic        sclk_q, cs_s, sclk_s, mosi_s, rise, fall, byte_done;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte, tx_shift, tx_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [9:0]  byte_cnt, byte_cnt_nx;
  logic [5:0]  frame_idx;
  logic [31:0] arg_shift;
  logic [39:0] resp_buf, dec_resp;
  logic [2:0]  resp_last, dec_last;
  logic [7:0]  init_cnt, idle8;
  logic        app_flag, read_go, frame_end, resp_shift;
  logic        crc_ok, dec_read, dec_ready_set, dec_ready_clr, dec_init_inc;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign rise      = sclk_s & ~sclk_q & ~cs_s;
  assign fall      = ~sclk_s & sclk_q & ~cs_s;
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_s};
  assign idle8     = {7'd0, ~card_ready};
  assign crc_ok    = (rx_byte == {crc7({2'b01, frame_idx, arg_shift}), 1'b1});

  // Command decode, evaluated while the CRC byte completes.
  always_comb begin
    dec_resp      = {8'h04 | idle8, 32'hFFFF_FFFF};
    dec_last      = 3'd0;
    dec_read      = 1'b0;
    dec_ready_set = 1'b0;
    dec_ready_clr = 1'b0;
    dec_init_inc  = 1'b0;
    if (CHECK_CRC && (frame_idx == 6'd0 || frame_idx == 6'd8) && !crc_ok) begin
      dec_resp[39:32] = 8'h08 | idle8;
    end else if (frame_idx == 6'd0) begin
      dec_resp[39:32] = 8'h01;
      dec_ready_clr   = 1'b1;
    end else if (frame_idx == 6'd8) begin
      dec_resp = {8'h01 | idle8, 8'h00, 8'h00, 4'h0, arg_shift[11:8], arg_shift[7:0]};
      dec_last = 3'd4;
    end else if (frame_idx == 6'd55) begin
      dec_resp[39:32] = idle8;
    end else if (frame_idx == 6'd41 && app_flag) begin
      if (init_cnt < POLLS) begin
        dec_resp[39:32] = 8'h01;
        dec_init_inc    = 1'b1;
      end else begin
        dec_resp[39:32] = 8'h00;
        dec_ready_set   = 1'b1;
      end
    end else if (frame_idx == 6'd58) begin
      dec_resp = {idle8, (card_ready ? 8'h40 : 8'h00), 8'hFF, 8'h80, 8'h00};
      dec_last = 3'd4;
    end else if (frame_idx == 6'd17) begin
      if (!card_ready)                        dec_resp[39:32] = 8'h05;
      else if (arg_shift > {6'd0, MAX_SECTOR}) dec_resp[39:32] = 8'h40;
      else begin
        dec_resp[39:32] = 8'h00;
        dec_read        = 1'b1;
      end
    end
  end

  // Next state and next outgoing byte, applied only at a byte boundary.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    byte_cnt_nx = byte_cnt;
    tx_nx       = 8'hFF;
    frame_end   = 1'b0;
    resp_shift  = 1'b0;
    unique case (state)
      HUNT:      if (rx_byte[7:6] == 2'b01) begin state_nx = CMD_BYTES; cnt_nx = 8'd4; end
      CMD_BYTES: if (cnt == 8'd0) begin
                   frame_end = 1'b1;
                   state_nx  = NCR;
                   cnt_nx    = 8'(RESP_DELAY - 1);
                 end else cnt_nx = cnt - 8'd1;
      NCR:       if (cnt == 8'd0) begin
                   state_nx   = RESP;
                   cnt_nx     = {5'd0, resp_last};
                   tx_nx      = resp_buf[39:32];
                   resp_shift = 1'b1;
                 end else cnt_nx = cnt - 8'd1;
      RESP:      if (cnt != 8'd0) begin
                   cnt_nx     = cnt - 8'd1;
                   tx_nx      = resp_buf[39:32];
                   resp_shift = 1'b1;
                 end else if (!read_go) state_nx = HUNT;
                 else if (ACCESS_DELAY == 0) begin state_nx = TOKEN; tx_nx = 8'hFE; end
                 else begin state_nx = ACCESS; cnt_nx = 8'(ACCESS_DELAY - 1); end
      ACCESS:    if (cnt == 8'd0) begin state_nx = TOKEN; tx_nx = 8'hFE; end
                 else cnt_nx = cnt - 8'd1;
      TOKEN:     begin state_nx = DATA; byte_cnt_nx = 10'd0; tx_nx = rd_data; end
      DATA:      if (byte_cnt == 10'd511) begin state_nx = CRC; cnt_nx = 8'd1; end
                 else begin byte_cnt_nx = byte_cnt + 10'd1; tx_nx = rd_data; end
      CRC:       if (cnt == 8'd0) state_nx = HUNT;
                 else cnt_nx = cnt - 8'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync    <= 2'b11;
      sclk_sync  <= 2'b00;
      mosi_sync  <= 2'b00;
      sclk_q     <= 1'b0;
      state      <= HUNT;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'hFF;
      miso       <= 1'b1;
      cnt        <= 8'd0;
      byte_cnt   <= 10'd0;
      frame_idx  <= 6'd0;
      arg_shift  <= 32'd0;
      resp_buf   <= 40'd0;
      resp_last  <= 3'd0;
      read_go    <= 1'b0;
      init_cnt   <= 8'd0;
      app_flag   <= 1'b0;
      card_ready <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'd0;
      rd_sector  <= 26'd0;
      rd_start   <= 1'b0;
      rd_strobe  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_q    <= sclk_s;
      cmd_valid <= 1'b0;
      rd_start  <= 1'b0;
      // 4th rising edge of the byte before each data byte requests that byte
      rd_strobe <= rise && (bit_cnt == 3'd3) &&
                   (state == TOKEN || (state == DATA && byte_cnt != 10'd511));
      if (cs_s) begin
        bit_cnt  <= 3'd0;
        miso     <= 1'b1;
        tx_shift <= 8'hFF;
        state    <= HUNT;
      end else begin
        if (rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (fall) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
        if (byte_done) begin
          state    <= state_nx;
          cnt      <= cnt_nx;
          byte_cnt <= byte_cnt_nx;
          tx_shift <= tx_nx;
          if (state == HUNT) frame_idx <= rx_byte[5:0];
          if (state == CMD_BYTES && cnt != 8'd0) arg_shift <= {arg_shift[23:0], rx_byte};
          if (resp_shift) resp_buf <= {resp_buf[31:0], 8'hFF};
          if (frame_end) begin
            cmd_valid <= 1'b1;
            cmd_index <= frame_idx;
            cmd_arg   <= arg_shift;
            resp_buf  <= dec_resp;
            resp_last <= dec_last;
            read_go   <= dec_read;
            app_flag  <= (frame_idx == 6'd55);
            if (dec_ready_clr) begin
              card_ready <= 1'b0;
              init_cnt   <= 8'd0;
            end
            if (dec_ready_set) card_ready <= 1'b1;
            if (dec_init_inc)  init_cnt   <= init_cnt + 8'd1;
            if (dec_read) begin
              rd_start  <= 1'b1;
              rd_sector <= arg_shift[25:0];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: a bit-banged SPI host drives command frames and
// compares every returned byte with a command-level card model.
module tb_sd_spi_responder;
  localparam int RESP_DELAY   = 1;
  localparam int ACCESS_DELAY = 2;
  localparam int INIT_POLLS   = 3;
  localparam logic [25:0] MAX_SECTOR = 26'h3FFFFFF;
  localparam int HALF = 40;  // 4 system clocks per SPI half period

  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b1, spi_clk = 1'b0, mosi = 1'b1;
  logic        miso, rd_start, rd_strobe, cmd_valid, card_ready;
  logic [25:0] rd_sector;
  logic [7:0]  rd_data = 8'h00;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int total = 0, bad = 0;
  int cv_cnt = 0, rs_cnt = 0, sb_cnt = 0, rd_idx = 0;
  logic [5:0]  cv_idx = '0;
  logic [31:0] cv_arg = '0;
  logic [25:0] rs_sec = '0;

  logic       m_ready = 1'b0, m_app = 1'b0;
  int         m_polls = 0;
  logic [7:0] exp_q[$];

  sd_spi_responder #(.RESP_DELAY(RESP_DELAY), .ACCESS_DELAY(ACCESS_DELAY),
                     .INIT_POLLS(INIT_POLLS), .MAX_SECTOR(MAX_SECTOR), .CHECK_CRC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .spi_clk(spi_clk), .mosi(mosi), .miso(miso),
    .rd_sector(rd_sector), .rd_start(rd_start), .rd_strobe(rd_strobe), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .card_ready(card_ready));

  initial forever #5 clk = ~clk;

  // Monitors and the sector byte source (byte n of a read is n & 0xFF).
  initial forever begin
    @(negedge clk);
    if (cmd_valid) begin cv_cnt++; cv_idx = cmd_index; cv_arg = cmd_arg; end
    if (rd_start)  begin rs_cnt++; rs_sec = rd_sector; rd_idx = 0; end
    if (rd_strobe) begin rd_data = rd_idx[7:0]; rd_idx++; sb_cnt++; end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of polynomial division by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [7:0] crc_byte(input logic [5:0] idx, input logic [31:0] arg);
    return {ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #(HALF) spi_clk = 1'b1;
      #(HALF) rx[i] = miso;
      spi_clk = 1'b0;
    end
  endtask

  // Card model: expected response bytes and whether a read starts.
  task automatic model(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                       output logic rd);
    logic [7:0] idle;
    idle = m_ready ? 8'h00 : 8'h01;
    rd = 1'b0;
    exp_q.delete();
    if ((idx == 0 || idx == 8) && crc != crc_byte(idx, arg)) exp_q.push_back(8'h08 | idle);
    else if (idx == 0) begin exp_q.push_back(8'h01); m_ready = 1'b0; m_polls = 0; end
    else if (idx == 8) begin
      exp_q.push_back(8'h01 | idle); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back({4'h0, arg[11:8]}); exp_q.push_back(arg[7:0]);
    end
    else if (idx == 55) exp_q.push_back(idle);
    else if (idx == 41 && m_app) begin
      if (m_polls < INIT_POLLS) begin exp_q.push_back(8'h01); m_polls++; end
      else begin exp_q.push_back(8'h00); m_ready = 1'b1; end
    end
    else if (idx == 58) begin
      exp_q.push_back(idle); exp_q.push_back(m_ready ? 8'h40 : 8'h00);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h80); exp_q.push_back(8'h00);
    end
    else if (idx == 17) begin
      if (!m_ready) exp_q.push_back(8'h05);
      else if (arg > {6'd0, MAX_SECTOR}) exp_q.push_back(8'h40);
      else begin exp_q.push_back(8'h00); rd = 1'b1; end
    end
    else exp_q.push_back(8'h04 | idle);
    m_app = (idx == 55);
  endtask

  // Sends one frame and checks the reply; ndata limits how much of a read is consumed.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                         input int ndata);
    logic [7:0] rx;
    logic       rd;
    int         cv0, rs0, sb0;
    model(idx, arg, crc, rd);
    cv0 = cv_cnt; rs0 = rs_cnt;
    xfer({2'b01, idx}, rx);
    for (int b = 3; b >= 0; b--) xfer(arg[b*8 +: 8], rx);
    xfer(crc, rx);
    for (int i = 0; i < RESP_DELAY; i++) begin xfer(8'hFF, rx); check("ncr", rx, 8'hFF); end
    foreach (exp_q[i]) begin xfer(8'hFF, rx); check($sformatf("resp_cmd%0d_b%0d", idx, i), rx, exp_q[i]); end
    check("cmd_valid_cnt", cv_cnt, cv0 + 1);
    check("cmd_index", cv_idx, idx);
    check("cmd_arg", cv_arg, arg);
    check("rd_start_cnt", rs_cnt, rs0 + int'(rd));
    if (rd) begin
      check("rd_sector", rs_sec, arg[25:0]);
      for (int i = 0; i < ACCESS_DELAY; i++) begin xfer(8'hFF, rx); check("access", rx, 8'hFF); end
      sb0 = sb_cnt;
      xfer(8'hFF, rx); check("token", rx, 8'hFE);
      for (int k = 0; k < ndata; k++) begin xfer(8'hFF, rx); check("data", rx, k & 8'hFF); end
      if (ndata == 512) begin
        xfer(8'hFF, rx); check("crc0", rx, 8'hFF);
        xfer(8'hFF, rx); check("crc1", rx, 8'hFF);
        xfer(8'hFF, rx); check("after_read", rx, 8'hFF);
        check("strobe_cnt", sb_cnt - sb0, 512);
      end
    end
  endtask

  initial begin
    logic [7:0]  rx;
    logic [31:0] a;
    logic [5:0]  bad_idx[8] = '{6'd1, 6'd2, 6'd9, 6'd12, 6'd13, 6'd16, 6'd24, 6'd59};
    int          sb_hold;
    #33;
    check("rst_miso", miso, 1'b1);
    check("rst_ready", card_ready, 1'b0);
    check("rst_cmd_index", cmd_index, 6'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_rd_sector", rd_sector, 26'd0);
    check("rst_pulses", {rd_start, rd_strobe, cmd_valid}, 3'b000);
    rst_n = 1'b1;
    #50;
    for (int i = 0; i < 10; i++) begin xfer(8'hFF, rx); check("cs_high_miso", rx, 8'hFF); end
    check("no_cmd_while_cs_high", cv_cnt, 0);
    cs = 1'b0;
    #80;
    run_cmd(6'd0, 32'h0, 8'h95, 0);
    run_cmd(6'd0, 32'h0, 8'h00, 0);
    run_cmd(6'd17, 32'h5, crc_byte(6'd17, 32'h5), 0);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      run_cmd(bad_idx[$urandom_range(0, 7)], a, 8'($urandom), 0);
    end
    run_cmd(6'd8, 32'h1AA, 8'h87, 0);
    for (int i = 0; i < 3; i++) begin
      a = {20'h0, 12'($urandom)};
      run_cmd(6'd8, a, ($urandom_range(0, 3) == 0) ? 8'h01 : crc_byte(6'd8, a), 0);
    end
    run_cmd(6'd41, 32'h40000000, crc_byte(6'd41, 32'h40000000), 0);
    for (int i = 0; i <= INIT_POLLS; i++) begin
      run_cmd(6'd55, 32'h0, crc_byte(6'd55, 32'h0), 0);
      run_cmd(6'd41, 32'h40000000, crc_byte(6'd41, 32'h40000000), 0);
      check("card_ready_poll", card_ready, m_ready);
    end
    check("card_ready_final", card_ready, 1'b1);
    run_cmd(6'd58, 32'h0, crc_byte(6'd58, 32'h0), 0);
    a = {6'd1 + 6'($urandom_range(0, 62)), 26'($urandom)};
    run_cmd(6'd17, a, crc_byte(6'd17, a), 0);
    run_cmd(6'd41, 32'h0, crc_byte(6'd41, 32'h0), 0);
    run_cmd(6'd17, 32'h5, crc_byte(6'd17, 32'h5), 512);

    a = {6'd0, 26'($urandom)};
    run_cmd(6'd17, a, crc_byte(6'd17, a), 100);
    cs = 1'b1;
    #200;
    sb_hold = sb_cnt;
    check("abort_miso", miso, 1'b1);
    check("abort_ready", card_ready, 1'b1);
    #2000;
    check("abort_no_strobe", sb_cnt, sb_hold);
    cs = 1'b0;
    #80;
    a = {6'd0, 26'($urandom)};
    run_cmd(6'd17, a, crc_byte(6'd17, a), 8);
    cs = 1'b1;
    #200;

    cs = 1'b0;
    #80;
    xfer(8'h40, rx);
    xfer(8'h00, rx);
    rst_n = 1'b0;
    #30;
    check("midrst_miso", miso, 1'b1);
    check("midrst_ready", card_ready, 1'b0);
    check("midrst_cmd_index", cmd_index, 6'd0);
    check("midrst_cmd_arg", cmd_arg, 32'd0);
    check("midrst_rd_sector", rd_sector, 26'd0);
    rst_n = 1'b1;
    m_ready = 1'b0; m_polls = 0; m_app = 1'b0;
    cs = 1'b1;
    #200;
    cs = 1'b0;
    #80;
    run_cmd(6'd55, 32'h0, crc_byte(6'd55, 32'h0), 0);
    cs = 1'b1;
    #200;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Device-side (card) end of the SPI-mode SD protocol: an SPI mode-0 slave that decodes 6-byte host command frames and returns R1/R3/R7 responses.
- Walks the card init sequence CMD0 -> CMD8 -> CMD55/ACMD41 and serves CMD17 single-sector reads from an external byte source.
- Used as the card model in host-controller benches and as an FPGA-side SD card emulator.
- Oversamples the host SPI signals on the system clock.

Parameters:
- RESP_DELAY, 1: 0xFF bytes (NCR) between the frame's last byte and the response; legal 1..8.
- ACCESS_DELAY, 2: 0xFF bytes between the CMD17 R1 and the 0xFE start token; legal 0..255.
- INIT_POLLS, 3: number of ACMD41s answered 0x01 before the card reports ready.
- MAX_SECTOR, 26'h3FFFFFF: highest legal CMD17 sector address.
- CHECK_CRC, 1: 1 = verify CRC7 on CMD0 and CMD8; 0 = ignore the CRC byte.

Ports:
- clk  in  1  system clock; must be at least 8x spi_clk
- rst_n  in  1  synchronous, active-low reset
- cs  in  1  host chip select, active low (asynchronous; 2-flop synchronised)
- spi_clk  in  1  host SPI clock, idle low (2-flop synchronised)
- mosi  in  1  host data (2-flop synchronised)
- miso  out  1  card data; 1 when idle
- rd_sector  out  26  sector latched from the CMD17 argument
- rd_start  out  1  one-clk pulse: read accepted, rd_sector valid
- rd_strobe  out  1  one-clk pulse: request the next data byte
- rd_data  in  8  data byte answering rd_strobe
- cmd_valid  out  1  one-clk pulse: a complete frame was decoded
- cmd_index  out  6  index of the last decoded command
- cmd_arg  out  32  argument of the last decoded command
- card_ready  out  1  1 after a successful ACMD41 init

Behaviour:
- Reset values: miso=1, rd_start=0, rd_strobe=0, cmd_valid=0, card_ready=0, cmd_index=0, cmd_arg=0, rd_sector=0.
  - Internal: init counter=0, app flag=0, FSM=HUNT.
- Bit engine:
  - Edges are detected on the synchronised spi_clk and act only while synchronised cs=0.
  - Rising edge: shift mosi into rx_shift, MSB first; bit_cnt++.
  - The 8th rising edge completes a byte and loads tx_shift with the next outgoing byte (0xFF if none).
  - Falling edge: miso <= tx_shift[7]; tx_shift shifts left, filling with 1.
- cs high:
  - bit_cnt=0, miso=1, FSM -> HUNT.
  - Any in-progress frame, response or read is aborted; rd_strobe stops.
  - card_ready, the init counter and the app flag are kept.
- FSM states: HUNT, CMD_BYTES, NCR, RESP, ACCESS, TOKEN, DATA, CRC.
- HUNT:
  - A received byte with bits[7:6]=2'b01 starts a frame; any other byte is ignored.
- CMD_BYTES:
  - Collects 4 argument bytes and the CRC byte.
  - After the CRC byte: decode, pulse cmd_valid for 1 clk with cmd_index/cmd_arg updated, then go to NCR.
  - A frame start byte arriving during RESP or DATA is ignored (no command overlap).
- NCR: sends RESP_DELAY bytes of 0xFF, then RESP.
- R1 idle bit = ~card_ready.
- Decode (the first matching rule wins):
  - CHECK_CRC=1, index 0 or 8, and CRC byte != {crc7,1} -> R1 = 0x08 | idle.
  - CMD0 -> R1 0x01; card_ready=0, init counter=0.
  - CMD8 -> R7 = 0x01|idle bit, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55 -> R1 = idle; app flag=1.
  - CMD41 with app flag=1:
    - If init counter < INIT_POLLS: R1 0x01, counter++.
    - Otherwise: R1 0x00, card_ready=1.
  - CMD58 -> R3 = R1 followed by OCR 0x40FF8000 once ready, 0x00FF8000 before ready (CCS bit = card_ready).
  - CMD17 while not ready -> R1 0x05.
  - CMD17 with arg > MAX_SECTOR -> R1 0x40; no data phase.
  - CMD17 otherwise -> R1 0x00; rd_sector=arg[25:0]; rd_start pulse.
    - Then ACCESS (ACCESS_DELAY bytes of 0xFF), TOKEN (0xFE), DATA (512 bytes), CRC (0xFF, 0xFF), then HUNT.
  - Any other index -> R1 0x04 | idle.
  - The app flag clears after any command other than CMD55.
- Data fetch:
  - For each of the 512 data bytes, rd_strobe pulses 1 clk after the 4th rising edge of the byte preceding it.
  - rd_data must be stable from 2 clk after rd_strobe until that byte boundary; it is sampled at the tx_shift load.
  - Byte counter is 10 bits; exactly 512 strobes per read.
- Reset mid-operation: rst_n=0 on any clk restores all reset values within that cycle, regardless of cs.

Test Plan:
- Send 10 bytes of 0xFF with cs high, then CMD0 (40 00 00 00 00 95) -> after 1 byte of 0xFF, R1 0x01; cmd_valid pulses with cmd_index=0.
- CMD8 (48 00 00 01 AA 87) -> R7 bytes 01 00 00 01 AA.
- CMD55+ACMD41 repeated with INIT_POLLS=3 -> R1 0x01,0x01,0x01 on the three ACMD41s, then 0x00 on the fourth; card_ready rises; CMD58 returns 00 40 FF 80 00.
- When ready, CMD17 arg 0x00000005 with a source returning (index & 0xFF) -> rd_start with rd_sector=5, R1 00, two 0xFF bytes, FE, bytes 00..FF twice, FF FF; exactly 512 rd_strobe pulses.
- CMD0 with CRC byte 0x00 -> R1 0x09; CMD17 before init -> R1 0x05, no rd_start.
- Raise cs after 100 data bytes, then lower it and send CMD17 -> the first read is aborted, the new read starts from byte 0, and card_ready stays 1.
